mul16_seq: RTL
==============

# mul16_seq

Sequential unsigned 16×16→32 multiplier built around a single instance of the team's 16-bit ripple adder (add16).
- The controller runs a shift-and-add loop: one adder pass per multiplier bit, 16 iterations.
- It exposes a start/busy/done handshake so the ALU can issue multiplies without a combinational array multiplier.
- It sits beside the ALU datapath and owns its add16 instance exclusively.

## Interface
Parameters: none (width fixed at 16; product 32).
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high; sampled on rising clk
- start  input  1  request; accepted only when not busy
- a  input  16  multiplicand, sampled on the accepting edge
- b  input  16  multiplier, sampled on the accepting edge
- busy  output  1  high while iterations are in progress
- done  output  1  single-cycle pulse when product becomes valid
- product  output  32  unsigned a×b; held stable from done until the next accepted start

## Operation
- Registers:
  - mcand[15:0]: latched a.
  - acc[15:0]: upper partial product.
  - mq[15:0]: multiplier shifting into the lower product.
  - cnt[4:0].
  - FSM state.
- The adder is instantiated with operands acc and mcand, carry_in tied to 0. It produces sum[15:0] and carry_out.
- FSM states:
  - IDLE: busy=0. If start: latch mcand=a, mq=b, acc=0, cnt=0; go to RUN.
  - RUN: busy=1. Each cycle:
    - If mq[0]=1: {c,s}={carry_out,sum}. Else: {c,s}={1'b0,acc}.
    - Then {acc,mq} <= {c,s,mq[15:1]} (33-bit value shifted right by 1). cnt <= cnt+1.
    - When cnt=15, the update completes the final iteration and the FSM goes to DONE.
  - DONE: done=1 for exactly this cycle; busy=0. If start: accept it exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- product = {acc,mq}, registered. It changes only during RUN and on the accepting edge; between those it holds its value.
- Arithmetic rules:
  - Unsigned only. No truncation: the full 32-bit result is always produced.
  - Carry out of the adder is never lost; it enters the 33-bit shift.
- start while busy=1: ignored, with no side effects. a and b are don't-care while busy.
- Reset (any state, including mid-RUN):
  - Next state IDLE.
  - acc=0, mq=0, mcand=0, cnt=0.
  - busy=0, done=0, product=0.
  - Any in-flight operation is discarded; no done pulse is produced for it.

## Timing
- start accepted at edge N. RUN occupies cycles N+1..N+16, with busy high for those 16 cycles. done is high in cycle N+17 and product is valid from that cycle.
- Latency: 17 cycles from the accepting edge to done.
- Back-to-back: start held high in the DONE cycle is accepted at that edge. The minimum issue interval is therefore 17 cycles.
- Reset values: busy=0, done=0, product=32'h0000_0000.
- Critical path: one 16-bit ripple carry plus the 2:1 mux. No combinational path from any input to any output.

## Configuration
- MUL16_ZERO_SKIP_EN:
  - Defined: on an accepting edge where a==0 or b==0, the FSM goes directly to DONE with product=0 (done in cycle N+1, busy never asserted).
  - Undefined: zero operands take the full 16 RUN cycles like any other operands. The result is still 0.
  - Non-zero operands behave identically in both builds.

## Test plan
- Reset then idle: assert reset 2 cycles with start=1 -> busy=0, done=0, product=0. No operation is started while reset is high.
- Basic: a=16'd3, b=16'd5 -> busy high 16 cycles, done pulse at N+17, product=32'd15, held until the next start.
- Max operands with carry: a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE_0001 at N+17. Checks adder carry_out propagation into the shift.
- Busy rejection and back-to-back:
  - While busy, pulse start with a=7, b=7 -> ignored; the first result (a=16'h1234, b=16'h0010 -> 32'h0001_2340) is unchanged.
  - start held in the DONE cycle with a=2, b=3 -> second done 17 cycles later, product=6.
- Reset mid-operation: start a=100, b=200; assert reset at cycle N+8 -> next cycle busy=0, product=0, no done pulse. A subsequent run of a=100, b=200 yields 32'd20000.
- Zero operand: a=0, b=16'hABCD.
  - MUL16_ZERO_SKIP_EN defined: done at N+1, busy never high, product=0.
  - Undefined: done at N+17, product=0.

Source files
------------

// File: rtl/mul16_seq.sv
// Sequential unsigned 16x16->32 shift-and-add multiplier around one add16 instance.
// Optional build macro: MUL16_ZERO_SKIP_EN (zero operand finishes in one cycle).

module add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [16:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[16];
endmodule

module mul16_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mq_q, mq_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [15:0] add_sum;
    logic        add_cout;
    logic [15:0] step_s;
    logic        step_c;
    logic        accept;
    logic        zero_op;

    add16 u_add16 (
        .a    (acc_q),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept = start && (state_q != S_RUN);

`ifdef MUL16_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = zero_op ? S_DONE : S_RUN;
                else        state_d = S_IDLE;
            end
            S_RUN:   if (cnt_q == 5'd15) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // One iteration: conditional add, then the 33-bit {carry,sum,mq} shifts right by one.
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        cnt_d   = cnt_q;
        step_c  = 1'b0;
        step_s  = acc_q;
        if (mq_q[0]) begin
            step_c = add_cout;
            step_s = add_sum;
        end
        if (accept) begin
            mcand_d = a;
            acc_d   = '0;
            mq_d    = zero_op ? '0 : b;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            acc_d = {step_c, step_s[15:1]};
            mq_d  = {step_s[0], mq_q[15:1]};
            cnt_d = cnt_q + 5'd1;
        end
    end

    assign product = {acc_q, mq_q};
endmodule
